fft_stage_sequencer: RTL



---
 rtl/fft_stage_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/fft_stage_sequencer.sv
// Stage controller that walks the FFT butterfly array through every stage, one coefficient bank per stage.
// Optional macro FFT_SEQ_COEFF_REG_EN adds a LOAD cycle and registers coeff_out; otherwise coeff_out is coeff_in.
module fft_stage_sequencer #(
  parameter int NBITS  = 11,
  parameter int N      = 32,
  parameter int STAGES = 7,
  parameter int BF_LAT = 3,
  localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int CW    = NBITS * N * 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  input  logic [CW-1:0] coeff_in,
  output logic [SW-1:0] coeff_addr,
  output logic [CW-1:0] coeff_out,
  output logic          bf_en,
  output logic          busy,
  output logic          done
);

  localparam int CNTW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   stage;
  logic [CNTW-1:0] cnt;

`ifdef FFT_SEQ_COEFF_REG_EN
  logic [CW-1:0] coeff_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stage <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bf_en <= 1'b0;
`ifdef FFT_SEQ_COEFF_REG_EN
      coeff_reg <= '0;
`endif
    end else begin
      bf_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            stage <= '0;
            busy  <= 1'b1;
`ifdef FFT_SEQ_COEFF_REG_EN
            state <= LOAD;
`else
            state <= FIRE;
            bf_en <= 1'b1;
`endif
          end
        end
`ifdef FFT_SEQ_COEFF_REG_EN
        LOAD: begin
          coeff_reg <= coeff_in;
          state     <= FIRE;
          bf_en     <= 1'b1;
        end
`endif
        FIRE: begin
          cnt   <= CNTW'(BF_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          // hold freezes both the countdown and the state
          if (!hold) begin
            if (cnt == '0) begin
              if (stage == SW'(STAGES - 1)) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                stage <= stage + 1'b1;
`ifdef FFT_SEQ_COEFF_REG_EN
                state <= LOAD;
`else
                state <= FIRE;
                bf_en <= 1'b1;
`endif
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign coeff_addr = stage;

`ifdef FFT_SEQ_COEFF_REG_EN
  assign coeff_out = coeff_reg;
`else
  assign coeff_out = coeff_in;
`endif

endmodule
